// File: rtl/gate_bist_pkg.sv
// gate_bist_pkg: shared types and constants for the gate_bist self-test engine.
//   state_t   - sweep FSM states
//   TT_*      - 4-bit truth tables, bit index = {a,b}
//   ERR_W     - width of the saturating mismatch counter
//   CNT_W     - width of the settle counter (SETTLE is 1..15)
//   sat_add() - saturating add used by the mismatch counter
package gate_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK,
        ST_FINISH
    } state_t;

    localparam logic [3:0] TT_NOR  = 4'h1;
    localparam logic [3:0] TT_NAND = 4'h7;
    localparam logic [3:0] TT_AND  = 4'h8;
    localparam logic [3:0] TT_OR   = 4'hE;
    localparam logic [3:0] TT_IMPL = 4'hB;

    localparam int ERR_W = 6;
    localparam int CNT_W = 4;

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    // Adds inc to acc and clamps at ERR_MAX instead of wrapping.
    function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] acc,
                                                 input logic [ERR_W-1:0] inc);
        logic [ERR_W:0] sum;
        sum = {1'b0, acc} + {1'b0, inc};
        return sum[ERR_W] ? ERR_MAX : sum[ERR_W-1:0];
    endfunction

endpackage

// File: rtl/gate_bist_popcount.sv
// bist_popcount: combinational population count of the per-gate mismatch vector.
//   bits  in  N   one bit per gate, 1 = mismatch
//   count out ERR_W  number of set bits (N <= 32, so it always fits)
module bist_popcount
    import gate_bist_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]     bits,
    output logic [ERR_W-1:0] count
);

    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + ERR_W'(bits[i]);
        end
    end

endmodule

// File: rtl/gate_bist.sv
// gate_bist: on-chip stimulus/checker for up to 32 two-input gates.
// Sweeps {a,b} through 00,01,10,11, waits SETTLE cycles after each vector,
// then compares every gate output with its expected truth-table bit.
//   clk            in   system clock
//   rst            in   synchronous active-high reset
//   start          in   one-cycle sweep request, honoured only in IDLE
//   a, b           out  stimulus operands shared by all gates
//   dut_out        in   gate outputs, bit g from gate g
//   busy           out  high in DRIVE, SETTLE and CHECK
//   done           out  one-cycle pulse in FINISH
//   pass           out  held: 1 when the last sweep saw no mismatch
//   fail_vec       out  held: bit g set if gate g ever mismatched
//   first_fail_idx out  held: {a,b} of the first vector with a mismatch
//   err_count      out  held: mismatching (gate,vector) pairs, saturating
module gate_bist
    import gate_bist_pkg::*;
#(
    parameter int                   N_GATES   = 8,
    parameter logic [4*N_GATES-1:0] EXP_TABLE = 32'hBBEE_8871,
    parameter int                   SETTLE    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               a,
    output logic               b,
    input  logic [N_GATES-1:0] dut_out,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [N_GATES-1:0] fail_vec,
    output logic [1:0]         first_fail_idx,
    output logic [ERR_W-1:0]   err_count
);

    // The counter is loaded with SETTLE-1 and SETTLE moves on when it reads
    // zero, so the FSM spends exactly SETTLE cycles in SETTLE.
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);

    state_t             state;
    state_t             next_state;
    logic [1:0]         vec;
    logic [CNT_W-1:0]   settle_cnt;
    logic [N_GATES-1:0] mismatch;
    logic [ERR_W-1:0]   mis_count;

    // Expected bit for gate g at the current vector is EXP_TABLE[4g + vec].
    always_comb begin
        mismatch = '0;
        for (int g = 0; g < N_GATES; g++) begin
            mismatch[g] = dut_out[g] ^ EXP_TABLE[4*g + int'(vec)];
        end
    end

    bist_popcount #(
        .N(N_GATES)
    ) u_popcount (
        .bits (mismatch),
        .count(mis_count)
    );

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) next_state = ST_DRIVE;
            end
            ST_DRIVE: begin
                busy       = 1'b1;
                next_state = ST_SETTLE;
            end
            ST_SETTLE: begin
                busy = 1'b1;
                if (settle_cnt == '0) next_state = ST_CHECK;
            end
            ST_CHECK: begin
                busy = 1'b1;
                next_state = (vec == 2'd3) ? ST_FINISH : ST_DRIVE;
            end
            ST_FINISH: begin
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a              <= 1'b0;
            b              <= 1'b0;
            vec            <= 2'd0;
            settle_cnt     <= '0;
            pass           <= 1'b0;
            fail_vec       <= '0;
            first_fail_idx <= 2'd0;
            err_count      <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        vec            <= 2'd0;
                        pass           <= 1'b0;
                        fail_vec       <= '0;
                        first_fail_idx <= 2'd0;
                        err_count      <= '0;
                    end
                end
                ST_DRIVE: begin
                    a          <= vec[1];
                    b          <= vec[0];
                    settle_cnt <= SETTLE_LOAD;
                end
                ST_SETTLE: begin
                    if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
                end
                ST_CHECK: begin
                    fail_vec  <= fail_vec | mismatch;
                    err_count <= sat_add(err_count, mis_count);
                    // fail_vec is cleared at start, so zero means nothing
                    // has failed yet in this sweep.
                    if ((|mismatch) && (fail_vec == '0)) first_fail_idx <= vec;
                    // pass is settled here so it is already valid while done
                    // is high in FINISH.
                    if (vec == 2'd3) pass <= ((fail_vec | mismatch) == '0);
                    else             vec  <= vec + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_bist.sv
// tb_gate_bist: directed bench for gate_bist.
// Three instances: A (defaults), B (32 gates, all outputs inverted),
// C (SETTLE=1). Gate outputs are modelled behaviourally with fault masks.
module tb_gate_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start_a, start_b, start_c;

    logic        a_a, b_a, busy_a, done_a, pass_a;
    logic [7:0]  out_a, fv_a;
    logic [1:0]  ffi_a;
    logic [5:0]  err_a;

    logic        a_b, b_b, busy_b, done_b, pass_b;
    logic [31:0] out_b, fv_b;
    logic [1:0]  ffi_b;
    logic [5:0]  err_b;

    logic        a_c, b_c, busy_c, done_c, pass_c;
    logic [7:0]  out_c, fv_c;
    logic [1:0]  ffi_c;
    logic [5:0]  err_c;

    logic [7:0]  s0_mask, s1_mask;
    logic        or6;

    int n_vec  = 0;
    int n_fail = 0;

    // Nominal gates: NOR, NAND, AND, AND, OR, OR, IMPL, IMPL.
    function automatic logic [7:0] gates8(input logic x, input logic y);
        logic [7:0] r;
        r[0] = ~(x | y);
        r[1] = ~(x & y);
        r[2] = x & y;
        r[3] = x & y;
        r[4] = x | y;
        r[5] = x | y;
        r[6] = ~x | y;
        r[7] = ~x | y;
        return r;
    endfunction

    function automatic logic [7:0] faulty8(input logic x, input logic y, input logic [7:0] s0,
                                           input logic [7:0] s1, input logic o6);
        logic [7:0] r;
        r = gates8(x, y);
        if (o6) r[6] = x | y;
        return (r & ~s0) | s1;
    endfunction

    always_comb out_a = faulty8(a_a, b_a, s0_mask, s1_mask, or6);
    always_comb out_b = ~{4{gates8(a_b, b_b)}};
    always_comb out_c = faulty8(a_c, b_c, s0_mask, s1_mask, or6);

    gate_bist u_a (
        .clk(clk), .rst(rst), .start(start_a), .a(a_a), .b(b_a), .dut_out(out_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .fail_vec(fv_a),
        .first_fail_idx(ffi_a), .err_count(err_a)
    );

    gate_bist #(.N_GATES(32), .EXP_TABLE({4{32'hBBEE_8871}}), .SETTLE(2)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .a(a_b), .b(b_b), .dut_out(out_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .fail_vec(fv_b),
        .first_fail_idx(ffi_b), .err_count(err_b)
    );

    gate_bist #(.N_GATES(8), .EXP_TABLE(32'hBBEE_8871), .SETTLE(1)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .a(a_c), .b(b_c), .dut_out(out_c),
        .busy(busy_c), .done(done_c), .pass(pass_c), .fail_vec(fv_c),
        .first_fail_idx(ffi_c), .err_count(err_c)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sel_done(input int w);
        return (w == 0) ? done_a : (w == 1) ? done_b : done_c;
    endfunction

    function automatic logic [1:0] sel_ab(input int w);
        return (w == 0) ? {a_a, b_a} : (w == 1) ? {a_b, b_b} : {a_c, b_c};
    endfunction

    function automatic logic sel_busy(input int w);
        return (w == 0) ? busy_a : (w == 1) ? busy_b : busy_c;
    endfunction

    task automatic set_start(input int w, input logic v);
        if (w == 0) start_a = v;
        else if (w == 1) start_b = v;
        else start_c = v;
    endtask

    // Pulses start and waits (bounded) for done, checking {a,b} during each
    // CHECK cycle and the start-to-done latency. Returns at the done cycle.
    task automatic run_sweep(input int w, input int settle, input string tag);
        int lat;
        lat = -1;
        set_start(w, 1'b1);
        for (int c = 1; c <= 60; c++) begin
            tick();
            set_start(w, 1'b0);
            for (int k = 0; k < 4; k++) begin
                if (c == 1 + k*(settle+2) + settle + 1)
                    check($sformatf("%s_ab_v%0d", tag, k), {30'd0, sel_ab(w)}, k);
            end
            if (sel_done(w)) begin
                lat = c;
                break;
            end
        end
        check({tag, "_latency"}, lat, 1 + 4*(settle+2));
        check({tag, "_busy_at_done"}, {31'd0, sel_busy(w)}, 32'd0);
        check({tag, "_ab_final"}, {30'd0, sel_ab(w)}, 32'd3);
    endtask

    typedef struct {
        string      name;
        logic [7:0] s0;
        logic [7:0] s1;
        logic       o6;
        logic       exp_pass;
        logic [7:0] exp_fv;
        logic [1:0] exp_ffi;
        logic [5:0] exp_err;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done;
        int first_done;
        int dt[3];
        int nd;

        tbl[0] = '{"clean",        8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 2'd0, 6'd0};
        tbl[1] = '{"g0_sa0",       8'h01, 8'h00, 1'b0, 1'b0, 8'h01, 2'd0, 6'd1};
        tbl[2] = '{"g6or_g3sa1",   8'h00, 8'h08, 1'b1, 1'b0, 8'h48, 2'd0, 6'd5};
        tbl[3] = '{"g2_sa0",       8'h04, 8'h00, 1'b0, 1'b0, 8'h04, 2'd3, 6'd1};
        tbl[4] = '{"g4g2_sa0",     8'h14, 8'h00, 1'b0, 1'b0, 8'h14, 2'd1, 6'd4};
        tbl[5] = '{"g6_sa1",       8'h00, 8'h40, 1'b0, 1'b0, 8'h40, 2'd2, 6'd1};
        tbl[6] = '{"g0_sa1",       8'h00, 8'h01, 1'b0, 1'b0, 8'h01, 2'd1, 6'd3};
        tbl[7] = '{"all_sa0",      8'hFF, 8'h00, 1'b0, 1'b0, 8'hFF, 2'd0, 6'd18};
        tbl[8] = '{"all_sa1",      8'h00, 8'hFF, 1'b0, 1'b0, 8'hFF, 2'd0, 6'd14};
        tbl[9] = '{"g1sa1_g3sa0",  8'h08, 8'h02, 1'b0, 1'b0, 8'h0A, 2'd3, 6'd2};

        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        s0_mask = 8'h00; s1_mask = 8'h00; or6 = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;
        tick();

        check("rst_ab",   {30'd0, a_a, b_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_done", {31'd0, done_a}, 32'd0);
        check("rst_pass", {31'd0, pass_a}, 32'd0);
        check("rst_fv",   {24'd0, fv_a}, 32'd0);
        check("rst_ffi",  {30'd0, ffi_a}, 32'd0);
        check("rst_err",  {26'd0, err_a}, 32'd0);

        // Table-driven sweeps on instance A.
        for (int i = 0; i < 10; i++) begin
            s0_mask = tbl[i].s0;
            s1_mask = tbl[i].s1;
            or6     = tbl[i].o6;
            tick();
            run_sweep(0, 2, tbl[i].name);
            check({tbl[i].name, "_pass"}, {31'd0, pass_a}, {31'd0, tbl[i].exp_pass});
            check({tbl[i].name, "_fv"},   {24'd0, fv_a},   {24'd0, tbl[i].exp_fv});
            check({tbl[i].name, "_ffi"},  {30'd0, ffi_a},  {30'd0, tbl[i].exp_ffi});
            check({tbl[i].name, "_err"},  {26'd0, err_a},  {26'd0, tbl[i].exp_err});
            tick();
            check({tbl[i].name, "_done_1cyc"}, {31'd0, done_a}, 32'd0);
        end

        // Results held in IDLE while inputs wiggle.
        s0_mask = 8'h00; s1_mask = 8'hFF;
        for (int i = 0; i < 6; i++) tick();
        check("hold_fv",  {24'd0, fv_a}, 32'h0A);
        check("hold_err", {26'd0, err_a}, 32'd2);
        check("hold_ffi", {30'd0, ffi_a}, 32'd3);

        // start re-pulsed during SETTLE: one sweep, one done.
        s0_mask = 8'h00; s1_mask = 8'h00;
        start_a = 1'b1;
        n_done = 0; first_done = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            start_a = (c == 2);
            if (done_a) begin
                n_done++;
                if (first_done < 0) first_done = c;
            end
        end
        check("repulse_ndone", n_done, 1);
        check("repulse_lat",   first_done, 17);
        check("repulse_pass",  {31'd0, pass_a}, 32'd1);

        // Reset at cycle 8 of a failing sweep.
        s0_mask = 8'h01;
        tick();
        start_a = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            start_a = 1'b0;
        end
        check("prerst_err", {26'd0, err_a}, 32'd1);
        check("prerst_ab",  {30'd0, a_a, b_a}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_ab",   {30'd0, a_a, b_a}, 32'd0);
        check("midrst_busy", {31'd0, busy_a}, 32'd0);
        check("midrst_fv",   {24'd0, fv_a}, 32'd0);
        check("midrst_ffi",  {30'd0, ffi_a}, 32'd0);
        check("midrst_err",  {26'd0, err_a}, 32'd0);
        check("midrst_pass", {31'd0, pass_a}, 32'd0);
        n_done = 0;
        for (int c = 0; c < 25; c++) begin
            if (done_a) n_done++;
            tick();
        end
        check("midrst_nodone", n_done, 0);

        // 32 gates, all inverted: saturating count.
        s0_mask = 8'h00;
        run_sweep(1, 2, "inv32");
        check("inv32_pass", {31'd0, pass_b}, 32'd0);
        check("inv32_fv",   fv_b, 32'hFFFF_FFFF);
        check("inv32_err",  {26'd0, err_b}, 32'd63);
        check("inv32_ffi",  {30'd0, ffi_b}, 32'd0);
        tick();

        // SETTLE=1: clean sweep, then back-to-back with start held high.
        run_sweep(2, 1, "s1_clean");
        check("s1_clean_pass", {31'd0, pass_c}, 32'd1);
        check("s1_clean_err",  {26'd0, err_c}, 32'd0);
        tick();
        s1_mask = 8'h40;
        tick();
        start_c = 1'b1;
        nd = 0;
        for (int c = 1; c <= 45; c++) begin
            tick();
            if (done_c) begin
                if (nd < 3) dt[nd] = c;
                nd++;
                check($sformatf("b2b_ffi_%0d", nd), {30'd0, ffi_c}, 32'd2);
                check($sformatf("b2b_err_%0d", nd), {26'd0, err_c}, 32'd1);
                check($sformatf("b2b_fv_%0d", nd),  {24'd0, fv_c}, 32'h40);
            end
        end
        start_c = 1'b0;
        check("b2b_ndone", nd, 3);
        if (nd >= 3) begin
            check("b2b_t0", dt[0], 13);
            check("b2b_t1", dt[1], 27);
            check("b2b_t2", dt[2], 41);
        end
        // Let the sweep started after the last done drain out.
        nd = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (done_c) nd++;
        end
        check("b2b_drain_ndone", nd, 1);
        check("b2b_idle_busy", {31'd0, busy_c}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
